// File: rtl/multicycle_cu_pkg.sv
// Shared definitions for the multicycle control unit.
//   state_t        : the eleven FSM states
//   OP_*           : supported RV32I opcodes
//   ALU_*          : alu_control codes driven to the datapath ALU
//   ALUOP_*        : internal FSM-to-alu_decoder operation class
//   RES_/SRCA_/SRCB_/IMM_* : datapath select encodings
//   imm_src_of()   : immediate-type decode from the opcode alone
package multicycle_cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_cu_alu_decoder.sv
// ALU operation decoder (purely combinational).
//   alu_op      in  2  operation class from the FSM (add / sub / funct-decoded)
//   funct3      in  3  instr[14:12]
//   funct7b5    in  1  instr[30]
//   op5         in  1  instr[5]; distinguishes R-type from I-type
//   alu_control out 3  ALU operation code
module alu_decoder
  import multicycle_cu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi has no funct7 field, so subtraction needs both op5 and funct7b5
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle control unit for an RV32I-subset datapath (lw, sw, R/I ALU, beq, jal).
// Moore FSM sequencing fetch/decode/execute/memory/writeback; drives every
// datapath select and enable, waits on mem_ready and counts retired instructions.
//   clk, reset (sync, active-high)
//   op, funct3, funct7b5 : instruction fields from IR
//   zero                 : ALU zero flag (branch decision)
//   mem_ready            : memory access completes this cycle
//   pc_write, adr_src, mem_write, ir_write, reg_write : datapath enables/selects
//   result_src, alu_src_a, alu_src_b, alu_control, imm_src : datapath selects
//   illegal_op           : one-cycle pulse in DECODE for an unsupported opcode
//   instret              : retired-instruction count (wraps)
module multicycle_cu
  import multicycle_cu_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_control,
  output logic [1:0]           imm_src,
  output logic                 illegal_op,
  output logic [INSTRET_W-1:0] instret
);

  state_t                 state_reg, state_next;
  logic [INSTRET_W-1:0]   instret_reg;
  logic [1:0]             alu_op;
  logic [2:0]             alu_control_dec;
  logic                   retire;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) instret_reg <= instret_reg + INSTRET_W'(1);
    end
  end

  assign instret = instret_reg;

  always_comb begin
    state_next = state_reg;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    retire     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute old_pc + imm so BEQ/JAL find the target in ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RD1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_op     = ALUOP_SUB;
        pc_write   = zero;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC <= target from ALUOut while the ALU forms old_pc + 4 for rd
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase

    alu_control = alu_control_dec;
    imm_src     = imm_src_of(op);

    // Reset cycle: everything quiet so an aborted store never writes
    if (reset) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = 3'b000;
      imm_src     = 2'b00;
      illegal_op  = 1'b0;
      retire      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_cu.sv
module tb_multicycle_cu;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] instret;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_instret = 0;

  always #5 clk = ~clk;

  multicycle_cu #(.INSTRET_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal_op(illegal_op),
    .instret(instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Packed enables {pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op}
  function automatic logic [31:0] en();
    return {26'd0, pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op};
  endfunction

  // FETCH with memory ready, then advance into DECODE
  task automatic fetch_ok(input string tag);
    mem_ready = 1'b1;
    #1;
    chk({tag, "_fetch_en"}, en(), 32'b100100);
    chk({tag, "_fetch_srcb"}, alu_src_b, 2'b10);
    chk({tag, "_fetch_res"}, result_src, 2'b10);
    chk({tag, "_fetch_instret"}, instret, exp_instret);
    next_cycle();
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  // Full R/I-type pass: FETCH, DECODE, EXEC, ALUWB
  task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] exp_ctrl, input logic [1:0] exp_srcb);
    set_instr(o, f3, f7);
    fetch_ok(tag);
    mem_ready = 1'b0;  // ignored outside FETCH/MEMREAD/MEMWRITE
    #1;
    chk({tag, "_dec_en"}, en(), 32'b0);
    chk({tag, "_dec_src"}, {alu_src_a, alu_src_b}, 4'b0101);
    next_cycle();
    #1;
    chk({tag, "_exec_src"}, {alu_src_a, alu_src_b}, {2'b10, exp_srcb});
    chk({tag, "_exec_ctrl"}, alu_control, exp_ctrl);
    chk({tag, "_exec_en"}, en(), 32'b0);
    next_cycle();
    #1;
    chk({tag, "_wb_en"}, en(), 32'b000010);
    chk({tag, "_wb_res"}, result_src, 2'b00);
    chk({tag, "_wb_instret"}, instret, exp_instret);
    exp_instret++;
    next_cycle();
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0);

    // Reset held two cycles with mem_ready high: outputs all quiet
    next_cycle();
    chk("rst1_en", en(), 32'b0);
    chk("rst1_sel", {result_src, alu_src_a, alu_src_b, imm_src}, 8'h00);
    chk("rst1_instret", instret, 32'd0);
    next_cycle();
    chk("rst2_en", en(), 32'b0);
    chk("rst2_instret", instret, 32'd0);
    reset = 1'b0;

    // add x3,x1,x2 ; sub ; addi with funct7b5 set (stays add) ; ori ; slt ; andi
    alu_instr("add",  7'b0110011, 3'b000, 1'b0, 3'b000, 2'b00);
    chk("add_retired", instret, 32'd1);
    alu_instr("sub",  7'b0110011, 3'b000, 1'b1, 3'b001, 2'b00);
    alu_instr("addi", 7'b0010011, 3'b000, 1'b1, 3'b000, 2'b01);
    alu_instr("ori",  7'b0010011, 3'b110, 1'b0, 3'b011, 2'b01);
    alu_instr("slt",  7'b0110011, 3'b010, 1'b0, 3'b101, 2'b00);
    alu_instr("andi", 7'b0010011, 3'b111, 1'b0, 3'b010, 2'b01);
    alu_instr("f3_1", 7'b0110011, 3'b001, 1'b0, 3'b000, 2'b00);

    // sw with 3 wait cycles in MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("sw_fetch_wait_en", en(), 32'b0);
    next_cycle();
    fetch_ok("sw");
    #1;
    chk("sw_dec_imm", imm_src, 2'b01);
    next_cycle();
    #1;
    chk("sw_memadr_src", {alu_src_a, alu_src_b, 1'b0, alu_control}, {4'b1001, 4'b0000});
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      chk($sformatf("sw_memwrite_en%0d", i), en(), 32'b011000);
      chk($sformatf("sw_memwrite_instret%0d", i), instret, exp_instret);
      next_cycle();
    end
    exp_instret++;
    chk("sw_retired", instret, exp_instret);

    // lw: one wait in MEMREAD, then MEMWB
    set_instr(7'b0000011, 3'b010, 1'b0);
    fetch_ok("lw");
    #1;
    chk("lw_dec_imm", imm_src, 2'b00);
    next_cycle();
    next_cycle();  // MEMADR
    mem_ready = 1'b0;
    #1;
    chk("lw_memread_en", en(), 32'b010000);
    next_cycle();
    mem_ready = 1'b1;
    #1;
    chk("lw_memread_rdy_en", en(), 32'b010000);
    next_cycle();
    #1;
    chk("lw_memwb_en", en(), 32'b000010);
    chk("lw_memwb_res", result_src, 2'b01);
    exp_instret++;
    next_cycle();
    chk("lw_retired", instret, exp_instret);

    // beq taken then not taken
    for (int t = 1; t >= 0; t--) begin
      set_instr(7'b1100011, 3'b000, 1'b0);
      fetch_ok($sformatf("beq%0d", t));
      next_cycle();  // DECODE -> BEQ
      zero = t[0];
      #1;
      chk($sformatf("beq%0d_pcw", t), pc_write, t[0]);
      chk($sformatf("beq%0d_ctrl", t), alu_control, 3'b001);
      chk($sformatf("beq%0d_imm", t), imm_src, 2'b10);
      chk($sformatf("beq%0d_src", t), {alu_src_a, alu_src_b}, 4'b1000);
      exp_instret++;
      next_cycle();
      zero = 1'b0;
      chk($sformatf("beq%0d_retired", t), instret, exp_instret);
    end

    // jal: retires only in ALUWB
    set_instr(7'b1101111, 3'b000, 1'b0);
    fetch_ok("jal");
    next_cycle();
    #1;
    chk("jal_en", en(), 32'b100000);
    chk("jal_src", {alu_src_a, alu_src_b}, 4'b0110);
    chk("jal_imm", imm_src, 2'b11);
    next_cycle();
    chk("jal_noretire", instret, exp_instret);
    #1;
    chk("jal_wb_en", en(), 32'b000010);
    exp_instret++;
    next_cycle();
    chk("jal_retired", instret, exp_instret);

    // illegal opcode
    set_instr(7'b0000000, 3'b000, 1'b0);
    fetch_ok("ill");
    #1;
    chk("ill_dec_en", en(), 32'b000001);
    next_cycle();
    mem_ready = 1'b1;
    #1;
    chk("ill_back_fetch", en(), 32'b100100);
    chk("ill_instret", instret, exp_instret);

    // Reset mid-MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0);
    fetch_ok("rstrd");
    next_cycle();
    next_cycle();
    mem_ready = 1'b0;
    #1;
    chk("rstrd_memread", en(), 32'b010000);
    reset = 1'b1;
    #1;
    chk("rstrd_rst_en", en(), 32'b0);
    next_cycle();
    reset = 1'b0;
    exp_instret = 0;
    mem_ready = 1'b1;
    #1;
    chk("rstrd_fetch", en(), 32'b100100);
    chk("rstrd_instret", instret, 32'd0);

    // Reset during a pending MEMWRITE: no write in the reset cycle
    set_instr(7'b0100011, 3'b010, 1'b0);
    fetch_ok("rstwr");
    next_cycle();
    next_cycle();
    mem_ready = 1'b0;
    #1;
    chk("rstwr_memwrite", mem_write, 1'b1);
    reset = 1'b1;
    #1;
    chk("rstwr_rst_en", en(), 32'b0);
    next_cycle();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rstwr_fetch", en(), 32'b100100);
    chk("rstwr_instret", instret, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
